sec_lock_pipe: RTL and testbench

Parametrised, pipelined single-error-correcting (SEC) decoder with a serially loaded logic-locking key. It generalises the 32-data/8-check combinational SEC benchmark into a streaming block with configurable data and check widths, a key-XOR input lock, valid/ready handshaking, and saturating error counters. It sits between a memory or link read port and the consumer, and serves as the sequential target for the team's locking/deobfuscation experiments.

---
 rtl/sec_lock_pipe_if.sv | 27 ++
 rtl/sec_lock_pipe.sv | 134 +++++++++++++
 tb/tb_sec_lock_pipe.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sec_lock_pipe_if.sv
// Word stream of the locked SEC decoder: received word in, corrected word out.
// The slave modport is the decoder side and the master modport is the producer/consumer side.
interface sec_lock_pipe_if #(
   parameter int DATA_W = 32,
   parameter int CHK_W  = 8
);
   logic              en;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] d_in;
   logic [CHK_W-1:0]  c_in;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] d_out;
   logic [CHK_W-1:0]  syn_out;
   logic [1:0]        st_out;

   modport slave (
      input  en, in_valid, d_in, c_in, out_ready,
      output in_ready, out_valid, d_out, syn_out, st_out
   );

   modport master (
      output en, in_valid, d_in, c_in, out_ready,
      input  in_ready, out_valid, d_out, syn_out, st_out
   );
endinterface

// File: rtl/sec_lock_pipe.sv
// Two-stage streaming SEC decoder with a key-XOR input lock and saturating error counters.
// Stage 1 captures the keyed word and its syndrome; stage 2 corrects it and holds the output.
module sec_lock_pipe #(
   parameter int                        DATA_W      = 32,
   parameter int                        CHK_W       = 8,
   parameter int                        CNT_W       = 16,
   parameter logic [DATA_W+CHK_W-1:0]   CORRECT_KEY = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             key_in,
   input  logic             key_shift,
   sec_lock_pipe_if.slave   bus,
   output logic             locked,
   output logic [CNT_W-1:0] corr_cnt,
   output logic [CNT_W-1:0] uncorr_cnt
);
   localparam int KEY_W = DATA_W + CHK_W;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef logic [DATA_W-1:0][CHK_W-1:0] col_t;

   // Column i is the i-th check pattern (ascending) with at least two bits set.
   function automatic col_t gen_cols();
      col_t cols;
      int   n;
      int   pc;
      cols = '0;
      n    = 0;
      for (int v = 1; v < (1 << CHK_W); v++) begin
         pc = 0;
         for (int b = 0; b < CHK_W; b++) pc += (v >> b) & 1;
         if (pc >= 2 && n < DATA_W) begin
            cols[n] = v[CHK_W-1:0];
            n++;
         end
      end
      return cols;
   endfunction

   localparam col_t COLS = gen_cols();

   logic [KEY_W-1:0]  key_reg;
   logic [KEY_W-1:0]  key_x;
   logic [DATA_W-1:0] d_eff;
   logic [CHK_W-1:0]  c_eff;
   logic [CHK_W-1:0]  syn_cap;

   logic              s1_valid;
   logic [DATA_W-1:0] s1_d;
   logic [CHK_W-1:0]  s1_syn;

   logic [DATA_W-1:0] d_fix;
   logic [1:0]        st_fix;
   logic              col_hit;

   logic              s2_adv;
   logic              in_ready;
   logic              out_fire;

   assign locked       = (key_reg != CORRECT_KEY);
   assign s2_adv       = !bus.out_valid || bus.out_ready;
   assign in_ready     = !s1_valid || s2_adv;
   assign bus.in_ready = in_ready;
   assign out_fire     = bus.out_valid && bus.out_ready;

   always_comb begin
      key_x   = key_reg ^ CORRECT_KEY;
      d_eff   = bus.d_in ^ key_x[DATA_W-1:0];
      c_eff   = (bus.en ? bus.c_in : '0) ^ key_x[KEY_W-1:DATA_W];
      syn_cap = c_eff;
      for (int i = 0; i < DATA_W; i++) begin
         if (d_eff[i]) syn_cap = syn_cap ^ COLS[i];
      end
   end

   // Columns are distinct, so at most one bit can match the syndrome.
   always_comb begin
      d_fix   = s1_d;
      col_hit = 1'b0;
      for (int i = 0; i < DATA_W; i++) begin
         if (s1_syn == COLS[i]) begin
            d_fix[i] = ~s1_d[i];
            col_hit  = 1'b1;
         end
      end
      if (s1_syn == '0)                 st_fix = 2'b00;
      else if (col_hit)                 st_fix = 2'b01;
      else if ($countones(s1_syn) == 1) st_fix = 2'b10;
      else                              st_fix = 2'b11;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         key_reg       <= '0;
         s1_valid      <= 1'b0;
         s1_d          <= '0;
         s1_syn        <= '0;
         bus.out_valid <= 1'b0;
         bus.d_out     <= '0;
         bus.syn_out   <= '0;
         bus.st_out    <= 2'b00;
         corr_cnt      <= '0;
         uncorr_cnt    <= '0;
      end else begin
         // Capture below reads the pre-shift key_reg through d_eff/syn_cap.
         if (key_shift) key_reg <= {key_reg[KEY_W-2:0], key_in};

         if (in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_d   <= d_eff;
               s1_syn <= syn_cap;
            end
         end

         if (s2_adv) begin
            bus.out_valid <= s1_valid;
            if (s1_valid) begin
               bus.d_out   <= d_fix;
               bus.syn_out <= s1_syn;
               bus.st_out  <= st_fix;
            end
         end

         if (out_fire) begin
            if ((bus.st_out == 2'b01 || bus.st_out == 2'b10) && corr_cnt != CNT_MAX)
               corr_cnt <= corr_cnt + 1'b1;
            if (bus.st_out == 2'b11 && uncorr_cnt != CNT_MAX)
               uncorr_cnt <= uncorr_cnt + 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_sec_lock_pipe.sv
// Bench for sec_lock_pipe: a vector table plus hand-built stall, key, saturation and reset sequences,
// all checked through an expected-result queue; a CNT_W=2 copy shares the stimulus.
module tb_sec_lock_pipe;
   localparam int DW = 32;
   localparam int CW = 8;
   localparam int KW = DW + CW;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic key_in = 1'b0;
   logic key_shift = 1'b0;
   logic locked, locked_s;
   logic [15:0] corr_cnt, uncorr_cnt;
   logic [1:0]  corr_s, uncorr_s;

   always #5 clk = ~clk;

   sec_lock_pipe_if #(.DATA_W(DW), .CHK_W(CW)) bus ();
   sec_lock_pipe_if #(.DATA_W(DW), .CHK_W(CW)) bus_s ();

   assign bus_s.en        = bus.en;
   assign bus_s.in_valid  = bus.in_valid;
   assign bus_s.d_in      = bus.d_in;
   assign bus_s.c_in      = bus.c_in;
   assign bus_s.out_ready = bus.out_ready;

   sec_lock_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(16), .CORRECT_KEY('0)) dut (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_shift(key_shift),
      .bus(bus), .locked(locked), .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
   );

   sec_lock_pipe #(.DATA_W(DW), .CHK_W(CW), .CNT_W(2), .CORRECT_KEY('0)) dut_s (
      .clk(clk), .rst_n(rst_n), .key_in(key_in), .key_shift(key_shift),
      .bus(bus_s), .locked(locked_s), .corr_cnt(corr_s), .uncorr_cnt(uncorr_s)
   );

   typedef struct packed {
      logic [DW-1:0] d;
      logic [CW-1:0] syn;
      logic [1:0]    st;
   } res_t;

   typedef struct {
      logic [DW-1:0] d;
      logic [CW-1:0] c;
      logic          en;
      res_t          exp;
   } vec_t;

   res_t          exp_q[$];
   res_t          exp_next;
   logic [CW-1:0] h_tb [DW];
   logic [KW-1:0] key_model = '0;
   int            exp_corr = 0;
   int            exp_uncorr = 0;
   int            n_pass = 0;
   int            n_total = 0;
   bit            rand_ready = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic res_t model(input logic [DW-1:0] d, input logic [CW-1:0] c,
                                  input logic e, input logic [KW-1:0] key);
      res_t r;
      logic [CW-1:0] s;
      int hit;
      r.d = d ^ key[DW-1:0];
      s   = (e ? c : '0) ^ key[KW-1:DW];
      for (int i = 0; i < DW; i++) if (r.d[i]) s = s ^ h_tb[i];
      hit = -1;
      for (int i = 0; i < DW; i++) if (h_tb[i] == s) hit = i;
      r.syn = s;
      if (s == '0) r.st = 2'b00;
      else if (hit >= 0) begin
         r.d[hit] = ~r.d[hit];
         r.st = 2'b01;
      end else if ($countones(s) == 1) r.st = 2'b10;
      else r.st = 2'b11;
      return r;
   endfunction

   function automatic int sat3(input int v);
      return (v > 3) ? 3 : v;
   endfunction

   // One clock: sample both handshakes at the falling edge, then return #1 after the rising edge.
   task automatic step(output bit acc);
      bit   xfer;
      res_t e;
      @(negedge clk);
      acc  = bus.in_valid && bus.in_ready;
      xfer = bus.out_valid && bus.out_ready;
      if (xfer) begin
         if (exp_q.size() == 0) chk("out_spurious", 64'(exp_q.size()), 64'd1);
         else begin
            e = exp_q.pop_front();
            chk("d_out", bus.d_out, e.d);
            chk("syn_out", bus.syn_out, e.syn);
            chk("st_out", bus.st_out, e.st);
            if (e.st == 2'b01 || e.st == 2'b10) exp_corr++;
            else if (e.st == 2'b11) exp_uncorr++;
         end
      end
      if (acc) exp_q.push_back(exp_next);
      @(posedge clk);
      #1;
      if (rand_ready) bus.out_ready = ($urandom_range(0, 3) != 0);
   endtask

   task automatic send(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic e, input res_t x);
      bit acc;
      acc = 1'b0;
      bus.d_in = d; bus.c_in = c; bus.en = e; bus.in_valid = 1'b1;
      exp_next = x;
      for (int k = 0; k < 50; k++) begin
         step(acc);
         if (acc) break;
      end
      if (!acc) chk("send_timeout", 64'(acc), 64'd1);
      bus.in_valid = 1'b0;
   endtask

   task automatic send_m(input logic [DW-1:0] d, input logic [CW-1:0] c, input logic e);
      send(d, c, e, model(d, c, e, key_model));
   endtask

   task automatic flush_and_check(input string tag);
      bit acc;
      bus.in_valid = 1'b0;
      for (int k = 0; k < 50; k++) begin
         if (exp_q.size() == 0) break;
         step(acc);
      end
      chk({tag, "_drain"}, 64'(exp_q.size()), 64'd0);
      chk({tag, "_corr_cnt"}, corr_cnt, 64'(exp_corr));
      chk({tag, "_uncorr_cnt"}, uncorr_cnt, 64'(exp_uncorr));
      chk({tag, "_corr_sat"}, corr_s, 64'(sat3(exp_corr)));
      chk({tag, "_uncorr_sat"}, uncorr_s, 64'(sat3(exp_uncorr)));
   endtask

   task automatic shift_bit(input logic b, output bit acc);
      key_in = b;
      key_shift = 1'b1;
      step(acc);
      key_shift = 1'b0;
      key_model = {key_model[KW-2:0], b};
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t          tbl[12];
      bit            acc;
      int            n;
      int            pc;
      logic [DW-1:0] hold_d;
      logic [DW-1:0] rd;
      logic [CW-1:0] rc;
      logic          re;

      n = 0;
      for (int v = 1; v < 256 && n < DW; v++) begin
         pc = 0;
         for (int b = 0; b < CW; b++) pc += (v >> b) & 1;
         if (pc >= 2) begin
            h_tb[n] = v[CW-1:0];
            n++;
         end
      end

      tbl[0]  = '{32'h0000_0001, 8'h03, 1'b1, '{32'h0000_0001, 8'h00, 2'b00}};
      tbl[1]  = '{32'h0000_0000, 8'h03, 1'b1, '{32'h0000_0001, 8'h03, 2'b01}};
      tbl[2]  = '{32'h0000_0000, 8'h10, 1'b1, '{32'h0000_0000, 8'h10, 2'b10}};
      tbl[3]  = '{32'h0000_0000, 8'h30, 1'b1, '{32'h0000_0000, 8'h30, 2'b11}};
      tbl[4]  = '{32'h0000_0000, 8'h1F, 1'b1, '{32'h0200_0000, 8'h1F, 2'b01}};
      tbl[5]  = '{32'h8000_0000, 8'h26, 1'b1, '{32'h8000_0000, 8'h00, 2'b00}};
      tbl[6]  = '{32'h8000_0000, 8'h00, 1'b1, '{32'h0000_0000, 8'h26, 2'b01}};
      tbl[7]  = '{32'h0000_0001, 8'hFF, 1'b0, '{32'h0000_0000, 8'h03, 2'b01}};
      tbl[8]  = '{32'h0000_0003, 8'h06, 1'b1, '{32'h0000_0003, 8'h00, 2'b00}};
      tbl[9]  = '{32'h0000_0003, 8'h00, 1'b1, '{32'h0000_0007, 8'h06, 2'b01}};
      tbl[10] = '{32'h0000_0000, 8'h80, 1'b1, '{32'h0000_0000, 8'h80, 2'b10}};
      tbl[11] = '{32'h0000_0000, 8'hFF, 1'b1, '{32'h0000_0000, 8'hFF, 2'b11}};

      bus.en = 1'b1; bus.in_valid = 1'b0; bus.d_in = '0; bus.c_in = '0; bus.out_ready = 1'b1;
      exp_next = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", bus.out_valid, 1'b0);
      chk("rst_d_out", bus.d_out, '0);
      chk("rst_syn_out", bus.syn_out, '0);
      chk("rst_st_out", bus.st_out, 2'b00);
      chk("rst_in_ready", bus.in_ready, 1'b1);
      chk("rst_locked", locked, 1'b0);
      chk("rst_corr_cnt", corr_cnt, '0);
      chk("rst_uncorr_cnt", uncorr_cnt, '0);
      rst_n = 1'b1;

      // Vector table, first word alone, then the rest back-to-back.
      for (int i = 0; i < 12; i++) begin
         send(tbl[i].d, tbl[i].c, tbl[i].en, tbl[i].exp);
         if (i == 0) flush_and_check("first");
      end
      flush_and_check("table");

      // Last key bit shifted on the same edge a word is captured: that word sees the old key.
      acc = 1'b0;
      for (int i = 0; i < KW - 1; i++) shift_bit(1'b0, acc);
      bus.d_in = 32'h0000_0001; bus.c_in = 8'h03; bus.en = 1'b1; bus.in_valid = 1'b1;
      exp_next = '{32'h0000_0001, 8'h00, 2'b00};
      shift_bit(1'b1, acc);
      bus.in_valid = 1'b0;
      chk("shift_capture_acc", 64'(acc), 64'd1);
      chk("locked_after_key", locked, 1'b1);
      send(32'h0000_0001, 8'h03, 1'b1, '{32'h0000_0001, 8'h03, 2'b01});
      send_m(32'h1234_5678, 8'h5A, 1'b1);
      flush_and_check("keyed");
      for (int i = 0; i < KW; i++) shift_bit(1'b0, acc);
      chk("locked_cleared", locked, 1'b0);

      // Backpressure: two words fill the pipe, the third must wait.
      bus.out_ready = 1'b0;
      send_m(32'hAAAA_0000, 8'h00, 1'b1);
      send_m(32'h0000_5555, 8'h11, 1'b1);
      hold_d = bus.d_out;
      chk("stall_head_d", hold_d, model(32'hAAAA_0000, 8'h00, 1'b1, key_model).d);
      bus.d_in = 32'hC0DE_0001; bus.c_in = 8'h00; bus.en = 1'b1; bus.in_valid = 1'b1;
      exp_next = model(32'hC0DE_0001, 8'h00, 1'b1, key_model);
      for (int i = 0; i < 3; i++) begin
         chk("stall_in_ready", bus.in_ready, 1'b0);
         step(acc);
         chk("stall_acc", 64'(acc), 64'd0);
         chk("stall_out_valid", bus.out_valid, 1'b1);
         chk("stall_d_hold", bus.d_out, hold_d);
      end
      bus.out_ready = 1'b1;
      send_m(32'hC0DE_0001, 8'h00, 1'b1);
      flush_and_check("stall");

      // Five more correctable words push the 2-bit counter well past its ceiling.
      for (int i = 0; i < 5; i++) begin
         rd = 32'h1 << $urandom_range(0, DW - 1);
         send_m(rd, 8'h00, 1'b1);
      end
      flush_and_check("sat");

      // Random traffic with random consumer stalls.
      rand_ready = 1'b1;
      for (int i = 0; i < 40; i++) begin
         rd = $urandom;
         rc = 8'($urandom);
         re = 1'($urandom_range(0, 1));
         if (i % 3 == 0) rc = model(rd, 8'h00, 1'b1, key_model).syn ^ h_tb[$urandom_range(0, DW - 1)];
         send_m(rd, rc, re);
      end
      rand_ready = 1'b0;
      bus.out_ready = 1'b1;
      flush_and_check("random");

      // Reset with words in flight discards them uncounted.
      send_m(32'h0000_00F0, 8'h00, 1'b1);
      send_m(32'h0000_0F00, 8'h00, 1'b1);
      send_m(32'h0000_F000, 8'h00, 1'b1);
      rst_n = 1'b0;
      step(acc);
      chk("midrst_out_valid", bus.out_valid, 1'b0);
      chk("midrst_in_ready", bus.in_ready, 1'b1);
      chk("midrst_corr_cnt", corr_cnt, '0);
      chk("midrst_uncorr_cnt", uncorr_cnt, '0);
      chk("midrst_corr_sat", corr_s, 2'd0);
      exp_q.delete();
      exp_corr = 0;
      exp_uncorr = 0;
      key_model = '0;
      rst_n = 1'b1;
      send_m(32'h0000_0000, 8'h05, 1'b1);
      step(acc);
      chk("post_rst_silent", bus.out_valid, 1'b1);
      flush_and_check("post_rst");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
